// File: rtl/writeback_stage_if.sv
// ============================================================================
// Module      : writeback_stage_if
// Description : Retire/memory-response/register-file bundle for writeback_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface writeback_stage_if #(
  parameter int XLEN = 32
) ();
  logic            valid_i;
  logic            ready_o;
  logic            reg_write_i;
  logic [4:0]      rd_i;
  logic [1:0]      wb_sel_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] pc_i;
  logic [2:0]      funct3_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            reg_write_o;
  logic [4:0]      wr_register_o;
  logic [XLEN-1:0] wr_data_o;
  logic            err_misalign_o;
  logic            err_timeout_o;

  modport slave (
    input  valid_i, reg_write_i, rd_i, wb_sel_i, alu_result_i, pc_i, funct3_i,
           mem_rvalid_i, mem_rdata_i,
    output ready_o, reg_write_o, wr_register_o, wr_data_o, err_misalign_o, err_timeout_o
  );

  modport master (
    output valid_i, reg_write_i, rd_i, wb_sel_i, alu_result_i, pc_i, funct3_i,
           mem_rvalid_i, mem_rdata_i,
    input  ready_o, reg_write_o, wr_register_o, wr_data_o, err_misalign_o, err_timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage; selects ALU / PC+4 / extended load data
//               and issues a single-cycle register-file write per instruction.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  writeback_stage_if.slave   bus
);

  localparam int c_CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            r_err_misalign;
  logic            r_err_timeout;
  logic            w_err_misalign_nxt;
  logic            w_err_timeout_nxt;

  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_result;

  logic            w_ready;
  logic            w_accept;
  logic            w_is_load;
  logic            w_misalign;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_direct_data;

  assign w_ready   = (r_state == S_IDLE) || (r_state == S_WRITE);
  assign w_accept  = bus.valid_i && w_ready;
  assign w_is_load = (bus.wb_sel_i == 2'b01);

  // Width/alignment legality of an incoming load, decided on the address bits alone
  always_comb begin
    w_misalign = 1'b0;
    case (bus.funct3_i)
      3'b001, 3'b101:         w_misalign = bus.alu_result_i[0];
      3'b010:                 w_misalign = |bus.alu_result_i[1:0];
      3'b011, 3'b110, 3'b111: w_misalign = 1'b1;
      default:                w_misalign = 1'b0;
    endcase
  end

  assign w_direct_data = (bus.wb_sel_i == 2'b10) ? (bus.pc_i + XLEN'(4)) : bus.alu_result_i;

  assign w_byte = bus.mem_rdata_i[{r_addr_lo, 3'b000} +: 8];
  assign w_half = bus.mem_rdata_i[{r_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = bus.mem_rdata_i;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = bus.mem_rdata_i;
    endcase
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_err_misalign_nxt = 1'b0;
    w_err_timeout_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_WRITE: begin
        if (w_accept) begin
          if (w_is_load && w_misalign) begin
            w_state_nxt        = S_IDLE;
            w_err_misalign_nxt = 1'b1;
          end else if (w_is_load) begin
            w_state_nxt = S_WAIT_MEM;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        // A response arriving on the final waiting edge still completes the load
        if (bus.mem_rvalid_i) begin
          w_state_nxt = S_WRITE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt       = S_IDLE;
          w_err_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_err_misalign <= w_err_misalign_nxt;
      r_err_timeout  <= w_err_timeout_nxt;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_result    <= '0;
    end else if (w_accept) begin
      r_rd        <= bus.rd_i;
      r_reg_write <= bus.reg_write_i;
      r_funct3    <= bus.funct3_i;
      r_addr_lo   <= bus.alu_result_i[1:0];
      if (!w_is_load) begin
        r_result <= w_direct_data;
      end
    end else if ((r_state == S_WAIT_MEM) && bus.mem_rvalid_i) begin
      r_result <= w_load_data;
    end
  end

  assign bus.ready_o        = w_ready;
  assign bus.reg_write_o    = (r_state == S_WRITE) && r_reg_write && (r_rd != 5'd0);
  assign bus.wr_register_o  = r_rd;
  assign bus.wr_data_o      = r_result;
  assign bus.err_misalign_o = r_err_misalign;
  assign bus.err_timeout_o  = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module      : tb_writeback_stage
// Description : Vector table plus scoreboard bench for writeback_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  localparam int XLEN = 32;
  localparam int TMO  = 4;
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_MIS  = 2'd2;
  localparam logic [1:0] K_TO   = 2'd3;
  localparam int NV = 18;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        regw;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          d;
    logic [1:0]  kind;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(XLEN)) bus ();

  writeback_stage #(.XLEN(XLEN), .MEM_TIMEOUT(TMO)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  ev_t  exp_q[$];
  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},        32'(bus.ready_o), 32'd1);
    chk({tag, "_reg_write"},    32'(bus.reg_write_o), 32'd0);
    chk({tag, "_wr_register"},  32'(bus.wr_register_o), 32'd0);
    chk({tag, "_wr_data"},      bus.wr_data_o, 32'd0);
    chk({tag, "_err_misalign"}, 32'(bus.err_misalign_o), 32'd0);
    chk({tag, "_err_timeout"},  32'(bus.err_timeout_o), 32'd0);
  endtask

  // Scoreboard: every visible write or error pulse must match the oldest expectation
  always @(negedge clk) begin : monitor
    logic [1:0] k;
    ev_t        e;
    if (!rst && (bus.reg_write_o || bus.err_misalign_o || bus.err_timeout_o)) begin
      k = bus.reg_write_o ? K_WR : (bus.err_misalign_o ? K_MIS : K_TO);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 32'(k), 32'(e.kind));
        if (e.kind == K_WR) begin
          chk("wr_register", 32'(bus.wr_register_o), 32'(e.rd));
          chk("wr_data", bus.wr_data_o, e.data);
        end
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 50 && !bus.ready_o; k++) @(negedge clk);
    if (!bus.ready_o) chk("ready_wait_expired", 32'(bus.ready_o), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bus.valid_i      = 1'b1;
    bus.wb_sel_i     = v.sel;
    bus.funct3_i     = v.f3;
    bus.rd_i         = v.rd;
    bus.reg_write_i  = v.regw;
    bus.alu_result_i = v.alu;
    bus.pc_i         = v.pc;
    wait_ready();
    if (v.kind != K_NONE) exp_q.push_back('{v.kind, v.rd, v.exp});
    @(negedge clk);
    bus.valid_i = 1'b0;
    if (v.sel == 2'b01 && v.kind != K_MIS) begin
      if (v.d > 0) begin
        for (int k = 0; k < v.d; k++) begin
          chk("ready_in_wait", 32'(bus.ready_o), 32'd0);
          if (k == v.d - 1) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = v.rdata;
          end
          @(negedge clk);
        end
        bus.mem_rvalid_i = 1'b0;
      end else begin
        for (int k = 0; k < TMO; k++) begin
          chk("ready_in_wait", 32'(bus.ready_o), 32'd0);
          @(negedge clk);
        end
        chk("ready_after_timeout", 32'(bus.ready_o), 32'd1);
      end
    end
    case (v.kind)
      K_WR:    chk("reg_write_pulse", 32'(bus.reg_write_o), 32'd1);
      K_MIS:   chk("err_misalign_pulse", 32'(bus.err_misalign_o), 32'd1);
      K_TO:    chk("err_timeout_pulse", 32'(bus.err_timeout_o), 32'd1);
      default: chk("no_write", 32'(bus.reg_write_o), 32'd0);
    endcase
    @(negedge clk);
    chk("pulse_single_cycle", 32'({bus.reg_write_o, bus.err_misalign_o, bus.err_timeout_o}), 32'd0);
  endtask

  initial begin
    bus.valid_i      = 1'b0;
    bus.reg_write_i  = 1'b0;
    bus.rd_i         = '0;
    bus.wb_sel_i     = '0;
    bus.alu_result_i = '0;
    bus.pc_i         = '0;
    bus.funct3_i     = '0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    //          sel    f3      rd     rw   alu           pc            rdata         d  kind    expected
    vecs[0]  = '{2'b00, 3'b000, 5'd5,  1'b1, 32'h00001234, 32'h00000000, 32'h0,        0, K_WR,   32'h00001234};
    vecs[1]  = '{2'b10, 3'b000, 5'd1,  1'b1, 32'h00000000, 32'hFFFFFFFC, 32'h0,        0, K_WR,   32'h00000000};
    vecs[2]  = '{2'b01, 3'b000, 5'd6,  1'b1, 32'h00000103, 32'h0,        32'h80FF7F01, 3, K_WR,   32'hFFFFFF80};
    vecs[3]  = '{2'b01, 3'b100, 5'd7,  1'b1, 32'h00000103, 32'h0,        32'h80FF7F01, 3, K_WR,   32'h00000080};
    vecs[4]  = '{2'b01, 3'b001, 5'd8,  1'b1, 32'h00000102, 32'h0,        32'h80FF7F01, 3, K_WR,   32'hFFFF80FF};
    vecs[5]  = '{2'b01, 3'b101, 5'd9,  1'b1, 32'h00000100, 32'h0,        32'h80FF7F01, 2, K_WR,   32'h00007F01};
    vecs[6]  = '{2'b01, 3'b010, 5'd10, 1'b1, 32'h00000100, 32'h0,        32'hDEADBEEF, 1, K_WR,   32'hDEADBEEF};
    vecs[7]  = '{2'b01, 3'b000, 5'd11, 1'b1, 32'h00000101, 32'h0,        32'h80FF7F01, 2, K_WR,   32'h0000007F};
    vecs[8]  = '{2'b01, 3'b010, 5'd12, 1'b1, 32'h00000102, 32'h0,        32'h0,        0, K_MIS,  32'h0};
    vecs[9]  = '{2'b01, 3'b011, 5'd12, 1'b1, 32'h00000100, 32'h0,        32'h0,        0, K_MIS,  32'h0};
    vecs[10] = '{2'b01, 3'b001, 5'd12, 1'b1, 32'h00000101, 32'h0,        32'h0,        0, K_MIS,  32'h0};
    vecs[11] = '{2'b01, 3'b010, 5'd12, 1'b1, 32'h00000104, 32'h0,        32'h0,        0, K_TO,   32'h0};
    vecs[12] = '{2'b01, 3'b010, 5'd12, 1'b1, 32'h00000108, 32'h0,        32'h11223344, 4, K_WR,   32'h11223344};
    vecs[13] = '{2'b00, 3'b000, 5'd0,  1'b1, 32'h0000ABCD, 32'h0,        32'h0,        0, K_NONE, 32'h0};
    vecs[14] = '{2'b11, 3'b000, 5'd13, 1'b1, 32'h00000055, 32'h00000400, 32'h0,        0, K_WR,   32'h00000055};
    vecs[15] = '{2'b00, 3'b000, 5'd14, 1'b0, 32'h00000077, 32'h0,        32'h0,        0, K_NONE, 32'h0};
    vecs[16] = '{2'b01, 3'b101, 5'd15, 1'b1, 32'h00000102, 32'h0,        32'h80FF7F01, 1, K_WR,   32'h000080FF};
    vecs[17] = '{2'b01, 3'b000, 5'd0,  1'b1, 32'h00000100, 32'h0,        32'h000000AA, 2, K_NONE, 32'h0};

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Back-to-back ALU ops must produce a write on every cycle
    for (int r = 1; r <= 4; r++) begin
      bus.valid_i      = 1'b1;
      bus.wb_sel_i     = 2'b00;
      bus.reg_write_i  = 1'b1;
      bus.rd_i         = 5'(r);
      bus.alu_result_i = 32'h00000100 + 32'(r);
      exp_q.push_back('{K_WR, 5'(r), 32'h00000100 + 32'(r)});
      @(negedge clk);
      chk("b2b_write", 32'(bus.reg_write_o), 32'd1);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(bus.reg_write_o), 32'd0);

    // Reset while waiting for memory drops the load entirely
    bus.valid_i      = 1'b1;
    bus.wb_sel_i     = 2'b01;
    bus.funct3_i     = 3'b010;
    bus.rd_i         = 5'd16;
    bus.alu_result_i = 32'h00000200;
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("rst_load_waiting", 32'(bus.ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("mid_load_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    chk("stale_rvalid_ignored", 32'(bus.reg_write_o), 32'd0);
    chk("stale_rvalid_ready", 32'(bus.ready_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
